npu_mem_top: RTL and testbench

// - NPU input-memory front end between the host register bus and the conv datapath.
// - Host loads a packed 8-bit image buffer and a byte-wide weight/bias buffer through one 32-bit data port.
// - Replays the stored bytes serially on D_OUT for downstream compute and debug.
// - Mode is selected by control_reg: 1 = load, 2 = readout, anything else = idle.

---
 rtl/npu_mem_top.sv | 140 ++++++++++++++
 tb/tb_npu_mem_top.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/npu_mem_top.sv
// npu_mem_top: host-loaded image/weight buffer with serial byte readout.
// Optional feature: define READOUT_WRAP_EN to make the readout stream
// repeat continuously. Without it, D_OUT drops to 0 after the last byte.
module npu_mem_top #(
  parameter int unsigned IMG_WORDS = 224,
  parameter int unsigned WGT_DEPTH = 18815,
  parameter int unsigned PTR_W     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic [31:0] control_reg,
  output logic [7:0]  D_OUT
);

  localparam int unsigned N_BYTES = IMG_WORDS * 4 + WGT_DEPTH;
  localparam int unsigned IMG_AW  = $clog2(IMG_WORDS);
  localparam int unsigned WGT_AW  = $clog2(WGT_DEPTH);

  localparam logic [PTR_W-1:0] IMG_END     = PTR_W'(IMG_WORDS);
  localparam logic [PTR_W-1:0] LOAD_END    = PTR_W'(IMG_WORDS + WGT_DEPTH);
  localparam logic [PTR_W-1:0] IMG_BYTES   = PTR_W'(IMG_WORDS * 4);
  localparam logic [PTR_W-1:0] STREAM_END  = PTR_W'(N_BYTES);
  localparam logic [PTR_W-1:0] STREAM_LAST = PTR_W'(N_BYTES - 1);

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_LOAD,
    MODE_READ
  } mode_e;

  logic [31:0] img_mem [IMG_WORDS];
  logic [7:0]  wgt_mem [WGT_DEPTH];

  logic [31:0]      mode_q,   mode_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       d_out_q,  d_out_d;

  mode_e            mode_sel;
  logic             arm;
  logic             img_we, wgt_we;
  logic [PTR_W-1:0] wr_off, rd_off;
  logic [31:0]      img_word;
  logic [7:0]       stream_byte;

  // Decode the requested mode and detect arm edges (mode change).
  always_comb begin
    mode_sel = MODE_IDLE;
    if (control_reg == 32'd1) begin
      mode_sel = MODE_LOAD;
    end else if (control_reg == 32'd2) begin
      mode_sel = MODE_READ;
    end
    arm = (control_reg != mode_q);
  end

  // Fetch the byte at rd_ptr from the image or weight buffer.
  always_comb begin
    rd_off   = rd_ptr_q - IMG_BYTES;
    img_word = img_mem[rd_ptr_q[IMG_AW+1:2]];
    unique case (rd_ptr_q[1:0])
      2'd0:    stream_byte = img_word[31:24];
      2'd1:    stream_byte = img_word[23:16];
      2'd2:    stream_byte = img_word[15:8];
      default: stream_byte = img_word[7:0];
    endcase
    if (rd_ptr_q >= IMG_BYTES) begin
      stream_byte = wgt_mem[rd_off[WGT_AW-1:0]];
    end
  end

  // Next-state for mode, pointers, output byte and write enables.
  always_comb begin
    mode_d   = control_reg;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    d_out_d  = d_out_q;
    img_we   = 1'b0;
    wgt_we   = 1'b0;
    wr_off   = wr_ptr_q - IMG_END;
    unique case (mode_sel)
      MODE_LOAD: begin
        if (arm) begin
          wr_ptr_d = '0;
        end else if (wr_ptr_q < IMG_END) begin
          img_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (wr_ptr_q < LOAD_END) begin
          wgt_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      MODE_READ: begin
        if (arm) begin
          rd_ptr_d = '0;
        end else if (rd_ptr_q < STREAM_END) begin
          d_out_d = stream_byte;
`ifdef READOUT_WRAP_EN
          rd_ptr_d = (rd_ptr_q == STREAM_LAST) ? '0 : rd_ptr_q + 1'b1;
`else
          rd_ptr_d = rd_ptr_q + 1'b1;
`endif
        end else begin
          // Pointer parked one past the end: stream exhausted.
          d_out_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Buffer writes; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (img_we) begin
      img_mem[wr_ptr_q[IMG_AW-1:0]] <= writedata;
    end
    if (wgt_we) begin
      wgt_mem[wr_off[WGT_AW-1:0]] <= writedata[7:0];
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      d_out_q  <= '0;
    end else begin
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      d_out_q  <= d_out_d;
    end
  end

  assign D_OUT = d_out_q;

endmodule

// File: tb/tb_npu_mem_top.sv
// Directed testbench for npu_mem_top (image/weight load and serial readout).
module tb_npu_mem_top;

  localparam int IMG_WORDS = 224;
  localparam int WGT_DEPTH = 18815;
  localparam int IMG_BYTES = IMG_WORDS * 4;
  localparam int N_BYTES   = IMG_BYTES + WGT_DEPTH;

  logic        clk;
  logic        reset;
  logic [31:0] writedata;
  logic [31:0] control_reg;
  logic [7:0]  D_OUT;

  int n_tests;
  int n_fail;

  npu_mem_top #(
    .IMG_WORDS(IMG_WORDS),
    .WGT_DEPTH(WGT_DEPTH),
    .PTR_W(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .writedata(writedata),
    .control_reg(control_reg),
    .D_OUT(D_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Image pattern word i = {4i, 4i+1, 4i+2, 4i+3} mod 256.
  function automatic logic [31:0] pat_word(input int i);
    logic [7:0] b;
    b = 8'((4 * i) % 256);
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  // Expected stream byte after the full load (weight 0 written as 0xABCD12EF).
  function automatic logic [7:0] full_byte(input int k);
    if (k < IMG_BYTES) return 8'(k % 256);
    if (k == IMG_BYTES) return 8'hEF;
    return 8'((k - IMG_BYTES) % 256);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    control_reg = 32'd0;
    writedata = 32'd0;
    #3;
    n_tests++;
    if (D_OUT !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout got %h exp %h", D_OUT, 8'h00);
    end
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_image_load_readout();
    control_reg = 32'd1;
    writedata = 32'd0;
    step();
    for (int i = 0; i < IMG_WORDS; i++) begin
      writedata = pat_word(i);
      step();
    end
    control_reg = 32'd2;
    writedata = 32'd0;
    step();
    n_tests++;
    if (D_OUT !== 8'h00) begin
      n_fail++;
      $display("FAIL readout_arm_hold got %h exp %h", D_OUT, 8'h00);
    end
    for (int k = 0; k < IMG_BYTES; k++) begin
      step();
      n_tests++;
      if (D_OUT !== 8'(k % 256)) begin
        n_fail++;
        $display("FAIL image_byte_%0d got %h exp %h", k, D_OUT, 8'(k % 256));
      end
    end
  endtask

  task automatic test_idle_hold();
    control_reg = 32'd0;
    step();
    control_reg = 32'd2;
    for (int e = 0; e < 10; e++) step();
    n_tests++;
    if (D_OUT !== 8'h08) begin
      n_fail++;
      $display("FAIL read_10_edges got %h exp %h", D_OUT, 8'h08);
    end
    control_reg = 32'd0;
    for (int e = 0; e < 5; e++) begin
      step();
      n_tests++;
      if (D_OUT !== 8'h08) begin
        n_fail++;
        $display("FAIL idle_hold_%0d got %h exp %h", e, D_OUT, 8'h08);
      end
    end
    control_reg = 32'd2;
    step();
    n_tests++;
    if (D_OUT !== 8'h08) begin
      n_fail++;
      $display("FAIL rearm_hold got %h exp %h", D_OUT, 8'h08);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (D_OUT !== 8'(k)) begin
        n_fail++;
        $display("FAIL restart_byte_%0d got %h exp %h", k, D_OUT, 8'(k));
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] exp_b [8];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    control_reg = 32'd1;
    writedata = 32'd0;
    step();
    for (int i = 0; i < 3; i++) begin
      writedata = 32'hDEADBEEF;
      step();
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (D_OUT !== 8'h00) begin
      n_fail++;
      $display("FAIL midload_reset_dout got %h exp %h", D_OUT, 8'h00);
    end
    @(negedge clk);
    reset = 1'b1;
    writedata = 32'd0;
    step();
    writedata = 32'h11223344;
    step();
    control_reg = 32'd2;
    writedata = 32'd0;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++;
      if (D_OUT !== exp_b[k]) begin
        n_fail++;
        $display("FAIL reload_byte_%0d got %h exp %h", k, D_OUT, exp_b[k]);
      end
    end
  endtask

  task automatic test_full_load_readout();
    control_reg = 32'd0;
    step();
    control_reg = 32'd1;
    writedata = 32'd0;
    step();
    for (int i = 0; i < IMG_WORDS; i++) begin
      writedata = pat_word(i);
      step();
    end
    for (int j = 0; j < WGT_DEPTH; j++) begin
      writedata = (j == 0) ? 32'hABCD12EF : {24'hABCD12, 8'(j % 256)};
      step();
    end
    for (int e = 0; e < 3; e++) begin
      writedata = 32'hFFFFFFFF;
      step();
    end
    control_reg = 32'd2;
    writedata = 32'd0;
    step();
    for (int k = 0; k < N_BYTES; k++) begin
      step();
      n_tests++;
      if (D_OUT !== full_byte(k)) begin
        n_fail++;
        $display("FAIL stream_byte_%0d got %h exp %h", k, D_OUT, full_byte(k));
      end
    end
    n_tests++;
    if (D_OUT !== 8'h7E) begin
      n_fail++;
      $display("FAIL last_byte got %h exp %h", D_OUT, 8'h7E);
    end
    for (int e = 0; e < 3; e++) begin
      logic [7:0] exp;
`ifdef READOUT_WRAP_EN
      exp = full_byte(e);
`else
      exp = 8'h00;
`endif
      step();
      n_tests++;
      if (D_OUT !== exp) begin
        n_fail++;
        $display("FAIL past_end_%0d got %h exp %h", e, D_OUT, exp);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_image_load_readout();
    test_idle_hold();
    test_reset_midload();
    test_full_load_readout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
